// File: rtl/uart_tx_arbiter_if.sv
// Bus between the uart_tx arbiter and its requesters / the shared uart_tx serializer.
//   req_valid_i / req_data_i / req_last_i : per-requester byte stream (8 bits per lane)
//   req_ready_o                          : per-requester accept strobe
//   grant_o                              : one-hot current owner, zero when idle
//   tx_data_o / tx_enable_o / tx_busy_i  : uart_tx data, start pulse and busy feedback
//   busy_o                               : arbiter not idle
// Signal names are from the arbiter's point of view.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req_valid_i;
   logic [8*NUM_REQ-1:0] req_data_i;
   logic [NUM_REQ-1:0]   req_last_i;
   logic [NUM_REQ-1:0]   req_ready_o;
   logic [NUM_REQ-1:0]   grant_o;
   logic [7:0]           tx_data_o;
   logic                 tx_enable_o;
   logic                 tx_busy_i;
   logic                 busy_o;

   // Arbiter side.
   modport slave (
      input  req_valid_i, req_data_i, req_last_i, tx_busy_i,
      output req_ready_o, grant_o, tx_data_o, tx_enable_o, busy_o
   );

   // Requesters plus uart_tx side.
   modport master (
      output req_valid_i, req_data_i, req_last_i, tx_busy_i,
      input  req_ready_o, grant_o, tx_data_o, tx_enable_o, busy_o
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one uart_tx serializer among NUM_REQ
// byte-stream requesters. The owner keeps the serializer until it sends a byte flagged
// last or until MAX_BURST bytes have gone out, whichever comes first.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_tx_arbiter_if.slave (requester streams, grant, uart_tx handshake, busy)
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned MAX_BURST = 64
) (
   input logic              clk,
   input logic              rst_n,
   uart_tx_arbiter_if.slave bus
);

   localparam int unsigned PtrW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [7:0]  BurstMax = 8'(MAX_BURST);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StGranted = 3'd1;
   localparam logic [2:0] StIssue   = 3'd2;
   localparam logic [2:0] StWaitHi  = 3'd3;
   localparam logic [2:0] StWaitLo  = 3'd4;

   logic [2:0]         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [PtrW-1:0]    owner_q, owner_d;
   logic [PtrW-1:0]    ptr_q, ptr_d;
   logic [7:0]         burst_q, burst_d;
   logic [7:0]         data_q, data_d;
   logic               last_q, last_d;

   // First valid requester searching upward from the pointer, with wrap.
   logic            pick_found;
   logic [PtrW-1:0] pick_idx;
   logic [PtrW-1:0] cand_idx;
   int unsigned     cand;

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand_idx   = '0;
      cand       = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand     = (32'(ptr_q) + i) % NUM_REQ;
         cand_idx = PtrW'(cand);
         if (!pick_found && bus.req_valid_i[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Owner's lane of the request bus.
   logic       own_valid;
   logic       own_last;
   logic [7:0] own_data;

   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (owner_q == PtrW'(k)) begin
            own_valid = bus.req_valid_i[k];
            own_last  = bus.req_last_i[k];
            own_data  = bus.req_data_i[8*k +: 8];
         end
      end
   end

   logic [PtrW-1:0] ptr_next;
   assign ptr_next = (owner_q == PtrW'(NUM_REQ - 1)) ? '0 : owner_q + PtrW'(1);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      burst_d = burst_q;
      data_d  = data_q;
      last_d  = last_q;
      case (state_q)
         StIdle: begin
            if (pick_found) begin
               grant_d = NUM_REQ'(1) << pick_idx;
               owner_d = pick_idx;
               burst_d = '0;
               state_d = StGranted;
            end
         end
         StGranted: begin
            // Owner going quiet holds the grant; nobody else may cut into the packet.
            if (own_valid && !bus.tx_busy_i) begin
               data_d  = own_data;
               last_d  = own_last;
               burst_d = burst_q + 8'd1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            state_d = StWaitHi;
         end
         StWaitHi: begin
            if (bus.tx_busy_i) begin
               state_d = StWaitLo;
            end
         end
         StWaitLo: begin
            if (!bus.tx_busy_i) begin
               // Burst limit forces release even mid-packet; the rest re-arbitrates.
               if (last_q || (burst_q == BurstMax)) begin
                  grant_d = '0;
                  ptr_d   = ptr_next;
                  state_d = StIdle;
               end else begin
                  state_d = StGranted;
               end
            end
         end
         default: begin
            grant_d = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         grant_q <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         burst_q <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         burst_q <= burst_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign bus.req_ready_o = ((state_q == StGranted) && !bus.tx_busy_i) ? grant_q : '0;
   assign bus.grant_o     = grant_q;
   assign bus.tx_data_o   = data_q;
   assign bus.tx_enable_o = (state_q == StIssue);
   assign bus.busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

   localparam int unsigned NR = 3;
   localparam int unsigned MB = 4;
   localparam int          QD = 64;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ  (NR),
      .MAX_BURST(MB)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Requester-side byte queues (what the bench drives).
   logic [7:0] d_data [NR][QD];
   logic       d_last [NR][QD];
   int         d_head [NR];
   int         d_tail [NR];

   // Reference model queues: same packets, consumed by plain round-robin rules.
   logic [7:0] m_data [NR][QD];
   logic       m_last [NR][QD];
   int         m_head [NR];
   int         m_tail [NR];
   int         m_ptr = 0;

   int exp_q[$];
   int obs_q[$];

   logic       en_flag   = 1'b0;
   logic       tx_busy_m = 1'b0;
   bit         long_busy = 1'b0;
   logic [7:0] sent_byte = 8'h00;
   int         dly = -1;
   int         cnt = 0;
   int         len = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int idx_of(input logic [NR-1:0] g);
      int r = 15;
      for (int i = 0; i < NR; i++) if (g[i]) r = i;
      return r;
   endfunction

   task automatic push(input int k, input logic [7:0] d, input logic l, input bit to_drv,
                       input bit to_mdl);
      if (to_drv) begin
         d_data[k][d_tail[k] % QD] = d;
         d_last[k][d_tail[k] % QD] = l;
         d_tail[k]++;
      end
      if (to_mdl) begin
         m_data[k][m_tail[k] % QD] = d;
         m_last[k][m_tail[k] % QD] = l;
         m_tail[k]++;
      end
   endtask

   task automatic push_pkt(input int k, input int base, input int n, input bit to_drv,
                           input bit to_mdl);
      for (int b = 0; b < n; b++) push(k, 8'(base + b), (b == n - 1), to_drv, to_mdl);
   endtask

   // Round-robin over requesters with pending bytes; each grant runs to a last byte or
   // MB bytes, then the pointer moves past the owner.
   task automatic model_run();
      int  own;
      int  c;
      int  n;
      bit  stop;
      bit  any;
      logic [7:0] d;
      logic l;
      forever begin
         any = 0;
         for (int k = 0; k < NR; k++) if (m_head[k] != m_tail[k]) any = 1;
         if (!any) break;
         own = -1;
         for (int i = 0; i < NR; i++) begin
            c = (m_ptr + i) % NR;
            if (own < 0 && m_head[c] != m_tail[c]) own = c;
         end
         n    = 0;
         stop = 0;
         while (!stop && m_head[own] != m_tail[own]) begin
            d = m_data[own][m_head[own] % QD];
            l = m_last[own][m_head[own] % QD];
            m_head[own]++;
            exp_q.push_back(own * 256 + int'(d));
            n++;
            if (l || n == MB) stop = 1;
         end
         m_ptr = (own + 1) % NR;
      end
   endtask

   function automatic bit drv_empty();
      bit e = 1;
      for (int k = 0; k < NR; k++) if (d_head[k] != d_tail[k]) e = 0;
      return e;
   endfunction

   function automatic bit tx_active();
      return tx_busy_m || (dly >= 0) || en_flag;
   endfunction

   task automatic wait_idle(input string tag, input int budget);
      bit ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (drv_empty() && bus.busy_o === 1'b0 && !tx_active()) ok = 1;
      end
      check({tag, "_done"}, 32'(ok), 32'd1);
   endtask

   task automatic compare(input string tag);
      int n;
      check({tag, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
      obs_q.delete();
      exp_q.delete();
   endtask

   // Requester driver: accept decided on the falling edge, queues advance after the rise.
   initial begin
      logic [NR-1:0] fire;
      bus.req_valid_i = '0;
      bus.req_data_i  = '0;
      bus.req_last_i  = '0;
      for (int k = 0; k < NR; k++) begin
         d_head[k] = 0;
         d_tail[k] = 0;
         m_head[k] = 0;
         m_tail[k] = 0;
      end
      forever begin
         @(negedge clk);
         fire = bus.req_valid_i & bus.req_ready_o;
         @(posedge clk);
         #1;
         for (int k = 0; k < NR; k++) begin
            if (fire[k]) d_head[k]++;
            if (d_head[k] != d_tail[k]) begin
               bus.req_valid_i[k]       = 1'b1;
               bus.req_data_i[8*k +: 8] = d_data[k][d_head[k] % QD];
               bus.req_last_i[k]        = d_last[k][d_head[k] % QD];
            end else begin
               bus.req_valid_i[k] = 1'b0;
               bus.req_last_i[k]  = 1'b0;
            end
         end
      end
   end

   // Monitor: records each transmitted byte with its owner; checks bus rules every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.tx_enable_o === 1'b1) begin
            obs_q.push_back(idx_of(bus.grant_o) * 256 + int'(bus.tx_data_o));
            sent_byte = bus.tx_data_o;
            en_flag   = 1'b1;
         end
         check("ready_only_owner", 32'(bus.req_ready_o & ~bus.grant_o), 32'd0);
         if (tx_busy_m) check("tx_data_stable", 32'(bus.tx_data_o), 32'(sent_byte));
      end
   end

   // uart_tx stand-in: busy rises 0..2 cycles after the enable pulse, lasts a few cycles.
   initial begin
      bus.tx_busy_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            tx_busy_m = 1'b0;
            dly       = -1;
            en_flag   = 1'b0;
         end else begin
            if (en_flag) begin
               en_flag = 1'b0;
               dly     = int'($urandom_range(0, 2));
               len     = long_busy ? 60 : int'($urandom_range(1, 6));
            end
            if (dly == 0) begin
               tx_busy_m = 1'b1;
               cnt       = len;
               dly       = -1;
            end else if (dly > 0) begin
               dly--;
            end else if (tx_busy_m) begin
               cnt--;
               if (cnt == 0) tx_busy_m = 1'b0;
            end
         end
         bus.tx_busy_i = tx_busy_m;
      end
   end

   initial begin
      bit ok;
      bit held;
      bit quiet;
      bit any;
      int npk;
      int plen;

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_grant", 32'(bus.grant_o), 32'd0);
      check("rst_ready", 32'(bus.req_ready_o), 32'd0);
      check("rst_enable", 32'(bus.tx_enable_o), 32'd0);
      check("rst_data", 32'(bus.tx_data_o), 32'd0);
      check("rst_busy", 32'(bus.busy_o), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Contention: two 3-byte packets at once, then a fresh tie.
      push_pkt(0, 'h11, 3, 1, 1);
      push_pkt(1, 'h21, 3, 1, 1);
      model_run();
      wait_idle("contend", 500);
      compare("contend");
      push_pkt(0, 'h31, 1, 1, 1);
      push_pkt(1, 'h41, 1, 1, 1);
      model_run();
      wait_idle("tie", 300);
      compare("tie");

      // Forced release: 6-byte packet against a 4-byte burst limit.
      push_pkt(0, 'h70, 6, 1, 1);
      push_pkt(1, 'h80, 1, 1, 1);
      model_run();
      wait_idle("burst", 800);
      compare("burst");

      // Single byte with cycle-exact latency.
      push(0, 8'hA5, 1'b1, 1, 1);
      @(negedge clk);
      check("lat_no_grant_yet", 32'(bus.grant_o), 32'd0);
      @(negedge clk);
      check("lat_grant", 32'(bus.grant_o), 32'b001);
      check("lat_ready", 32'(bus.req_ready_o), 32'b001);
      check("lat_no_enable", 32'(bus.tx_enable_o), 32'd0);
      @(negedge clk);
      check("lat_enable", 32'(bus.tx_enable_o), 32'd1);
      check("lat_data", 32'(bus.tx_data_o), 32'hA5);
      check("lat_ready_off", 32'(bus.req_ready_o), 32'd0);
      model_run();
      wait_idle("single", 300);
      compare("single");
      check("single_grant_clear", 32'(bus.grant_o), 32'd0);
      check("single_busy_clear", 32'(bus.busy_o), 32'd0);

      // Fairness: requester 1 arrives while requester 0 owns; it goes next.
      for (int p = 0; p < 4; p++) push(0, 8'(8'h50 + p), 1'b1, 1, 0);
      push(0, 8'h50, 1'b1, 0, 1);
      model_run();
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (bus.grant_o === 3'b001) ok = 1;
      end
      check("fair_r0_owns", 32'(ok), 32'd1);
      push(1, 8'h60, 1'b1, 1, 1);
      for (int p = 1; p < 4; p++) push(0, 8'(8'h50 + p), 1'b1, 0, 1);
      model_run();
      wait_idle("fair", 800);
      compare("fair");

      // Stall: owner (requester 2) goes quiet mid-packet while requester 0 waits.
      push(2, 8'h90, 1'b0, 1, 1);
      push(2, 8'h91, 1'b0, 0, 1);
      push(2, 8'h92, 1'b1, 0, 1);
      push(0, 8'hB0, 1'b1, 1, 1);
      model_run();
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (d_head[2] == d_tail[2] && obs_q.size() == 1 && !tx_active()) ok = 1;
      end
      check("stall_first_byte", 32'(ok), 32'd1);
      held  = 1;
      quiet = 1;
      repeat (1000) begin
         @(negedge clk);
         if (bus.grant_o !== 3'b100) held = 0;
         if (bus.tx_enable_o !== 1'b0) quiet = 0;
      end
      check("stall_grant_held", 32'(held), 32'd1);
      check("stall_no_enable", 32'(quiet), 32'd1);
      push(2, 8'h91, 1'b0, 1, 0);
      push(2, 8'h92, 1'b1, 1, 0);
      wait_idle("stall", 500);
      compare("stall");

      // Random packet mixes against the model.
      for (int r = 0; r < 6; r++) begin
         any = 0;
         for (int k = 0; k < NR; k++) begin
            if ($urandom_range(0, 1) == 1 || (k == NR - 1 && !any)) begin
               npk = int'($urandom_range(1, 2));
               for (int p = 0; p < npk; p++) begin
                  plen = int'($urandom_range(1, 6));
                  for (int b = 0; b < plen; b++)
                     push(k, 8'($urandom_range(0, 255)), (b == plen - 1), 1, 1);
               end
               any = 1;
            end
         end
         model_run();
         wait_idle($sformatf("rand%0d", r), 3000);
         compare($sformatf("rand%0d", r));
      end

      // Reset while waiting for the serializer to finish.
      long_busy = 1'b1;
      push(1, 8'hC3, 1'b1, 1, 1);
      model_run();
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (tx_busy_m) ok = 1;
      end
      check("rstmid_tx_busy", 32'(ok), 32'd1);
      @(negedge clk);
      check("rstmid_grant_before", 32'(bus.grant_o), 32'b010);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_grant", 32'(bus.grant_o), 32'd0);
      check("rstmid_ready", 32'(bus.req_ready_o), 32'd0);
      check("rstmid_enable", 32'(bus.tx_enable_o), 32'd0);
      check("rstmid_data", 32'(bus.tx_data_o), 32'd0);
      check("rstmid_busy", 32'(bus.busy_o), 32'd0);
      compare("rstmid_sent");
      m_ptr     = 0;
      long_busy = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push(1, 8'hD1, 1'b1, 1, 1);
      push(0, 8'hE1, 1'b1, 1, 1);
      model_run();
      wait_idle("post_rst", 300);
      compare("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
